// File: rtl/systolic_pkg.sv
// Shared parameters and types for the systolic MAC array and its result drain.
package systolic_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int N_DEF          = 3;
  localparam int M_DEF          = 3;

  // Width of an element index k for an n x m array (at least one bit)
  function automatic int idx_width(input int n, input int m);
    return (n * m > 1) ? $clog2(n * m) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_width(N_DEF, M_DEF);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_t;

endpackage

// File: rtl/systolic_drain_if.sv
// Valid/ready result stream from the drain to the downstream sink.
interface systolic_drain_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 4
);

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [IDX_W-1:0]      out_index;
  logic                  out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/systolic_drain.sv
// Snapshots the N x M accumulator array on load and streams it out row-major.
// The array is free to start the next accumulation as soon as the snapshot is taken.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N          = N_DEF,
  parameter int M          = M_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [N*M*DATA_WIDTH-1:0] c_flat,
  systolic_drain_if.master          out_if,
  output logic                      busy,
  output logic                      overrun
);

  localparam int              NUM_EL = N * M;
  localparam int              IDX_W  = idx_width(N, M);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_EL - 1);

  drain_state_t          state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] snap_q [NUM_EL];
  logic [DATA_WIDTH-1:0] snap_d [NUM_EL];
  logic                  overrun_q, overrun_d;
  logic                  busy_q, busy_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]      out_index_q, out_index_d;
  logic                  out_last_q, out_last_d;
  logic                  xfer;
  logic                  capture;

  // Next-state logic: capture, advance on transfer, flag dropped loads.
  // Outputs are precomputed from the next state so they can all be registered.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    overrun_d = overrun_q;
    capture   = 1'b0;
    xfer      = (state_q == STREAM) && out_if.out_ready;

    case (state_q)
      IDLE: begin
        if (load) begin
          capture = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer && idx_q == LAST) begin
          // A load landing on the final transfer is the back-to-back case, not an overrun
          if (load) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end else begin
          if (xfer) idx_d = idx_q + IDX_W'(1);
          if (load) overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    if (capture) begin
      idx_d = '0;
      for (int k = 0; k < NUM_EL; k++) begin
        snap_d[k] = c_flat[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    busy_d      = (state_d == STREAM);
    out_valid_d = (state_d == STREAM);
    out_data_d  = (state_d == STREAM) ? snap_d[idx_d] : '0;
    out_index_d = (state_d == STREAM) ? idx_d : '0;
    out_last_d  = (state_d == STREAM) && (idx_d == LAST);
  end

  // State, snapshot and registered outputs; reset aborts any drain immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      snap_q      <= '{default: '0};
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_index = out_index_q;
  assign out_if.out_last  = out_last_q;
  assign busy             = busy_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain: stimulus queues expected elements,
// a negedge monitor pops and compares on every transfer and checks stall hold.
module tb_systolic_drain;
  import systolic_pkg::*;

  localparam int DW = 32;
  localparam int N  = 3;
  localparam int M  = 3;
  localparam int NE = N * M;
  localparam int IW = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] index;
    logic          last;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             load;
  logic [NE*DW-1:0] c_flat;
  logic             busy;
  logic             overrun;

  systolic_drain_if #(.DATA_WIDTH(DW), .IDX_W(IW)) out_if ();

  systolic_drain #(.DATA_WIDTH(DW), .N(N), .M(M)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .c_flat  (c_flat),
    .out_if  (out_if),
    .busy    (busy),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_c(input int base);
    for (int k = 0; k < NE; k++) c_flat[k*DW +: DW] = DW'(base + k);
  endtask

  task automatic push_seq(input int base);
    exp_t e;
    for (int k = 0; k < NE; k++) begin
      e.data  = DW'(base + k);
      e.index = IW'(k);
      e.last  = (k == NE - 1);
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) cyc();
    chk("drain_timeout_busy", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: compare every accepted element, and check held values across stalls
  logic          held_v = 1'b0;
  logic [DW-1:0] held_data;
  logic [IW-1:0] held_index;
  logic          held_last;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_if.out_valid) begin
        chk("stall_data",  out_if.out_data, held_data);
        chk("stall_index", {28'd0, out_if.out_index}, {28'd0, held_index});
        chk("stall_last",  {31'd0, out_if.out_last}, {31'd0, held_last});
      end
      if (out_if.out_valid && out_if.out_ready) begin
        held_v = 1'b0;
        if (sb.size() == 0) begin
          chk("unexpected_element", out_if.out_data, 32'hDEAD_BEEF);
        end else begin
          e = sb.pop_front();
          chk("sb_data",  out_if.out_data, e.data);
          chk("sb_index", {28'd0, out_if.out_index}, {28'd0, e.index});
          chk("sb_last",  {31'd0, out_if.out_last}, {31'd0, e.last});
        end
      end else if (out_if.out_valid) begin
        held_v     = 1'b1;
        held_data  = out_if.out_data;
        held_index = out_if.out_index;
        held_last  = out_if.out_last;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int unsigned pat [4] = '{1, 0, 0, 1};

  initial begin
    rst = 1'b1;
    load = 1'b0;
    c_flat = '0;
    out_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",   {31'd0, out_if.out_valid}, 32'd0);
    chk("rst_data",    out_if.out_data, 32'd0);
    chk("rst_index",   {28'd0, out_if.out_index}, 32'd0);
    chk("rst_last",    {31'd0, out_if.out_last}, 32'd0);
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    cyc();

    // Full drain with ready held high
    load = 1'b1; set_c(1); push_seq(1); out_if.out_ready = 1'b1;
    cyc();
    load = 1'b0;
    chk("t1_first_valid", {31'd0, out_if.out_valid}, 32'd1);
    chk("t1_first_index", {28'd0, out_if.out_index}, 32'd0);
    repeat (NE) cyc();
    chk("t1_idle_busy",  {31'd0, busy}, 32'd0);
    chk("t1_idle_valid", {31'd0, out_if.out_valid}, 32'd0);
    cyc();

    // Ready toggling 1,0,0,1,...
    load = 1'b1; set_c(1); push_seq(1); out_if.out_ready = 1'b1;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 200 && busy; i++) begin
      out_if.out_ready = pat[i % 4][0];
      cyc();
    end
    chk("t2_done_busy", {31'd0, busy}, 32'd0);
    chk("t2_overrun",   {31'd0, overrun}, 32'd0);
    out_if.out_ready = 1'b1;
    cyc();

    // Load coincident with the last transfer: zero-bubble back-to-back
    load = 1'b1; set_c(1); push_seq(1);
    cyc();
    load = 1'b0;
    repeat (NE - 1) cyc();
    chk("t4_at_last", {31'd0, out_if.out_last}, 32'd1);
    load = 1'b1; set_c(10); push_seq(10);
    cyc();
    load = 1'b0;
    chk("t4_b2b_valid", {31'd0, out_if.out_valid}, 32'd1);
    chk("t4_b2b_data",  out_if.out_data, 32'd10);
    chk("t4_b2b_index", {28'd0, out_if.out_index}, 32'd0);
    wait_idle(50);
    chk("t4_overrun", {31'd0, overrun}, 32'd0);
    cyc();

    // Inputs changing after capture must not leak into the stream
    load = 1'b1; set_c(1); push_seq(1);
    cyc();
    load = 1'b0;
    set_c(100);
    cyc();
    set_c(200);
    wait_idle(50);
    cyc();

    // Load mid-stream at k=4 is dropped and flags overrun
    load = 1'b1; set_c(1); push_seq(1);
    cyc();
    load = 1'b0;
    repeat (4) cyc();
    chk("t3_at_k4", {28'd0, out_if.out_index}, 32'd4);
    load = 1'b1; set_c(10);
    cyc();
    load = 1'b0;
    chk("t3_overrun_set", {31'd0, overrun}, 32'd1);
    chk("t3_continue_index", {28'd0, out_if.out_index}, 32'd5);
    wait_idle(50);
    chk("t3_overrun_sticky", {31'd0, overrun}, 32'd1);
    cyc();
    chk("t3_overrun_sticky2", {31'd0, overrun}, 32'd1);

    // Asynchronous reset while k=6 is presented
    load = 1'b1; set_c(1); push_seq(1);
    cyc();
    load = 1'b0;
    repeat (6) cyc();
    chk("t5_at_k6", {28'd0, out_if.out_index}, 32'd6);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("t5_async_valid",   {31'd0, out_if.out_valid}, 32'd0);
    chk("t5_async_busy",    {31'd0, busy}, 32'd0);
    chk("t5_async_data",    out_if.out_data, 32'd0);
    chk("t5_async_overrun", {31'd0, overrun}, 32'd0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t5_post_valid", {31'd0, out_if.out_valid}, 32'd0);
    end

    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_drain.md
# systolic_drain

Result-readout block for the N×M systolic MAC array. On the array's `load` strobe it snapshots all N·M accumulator values into a local buffer, then streams them out one element per handshake, in row-major order, over a valid/ready interface. It sits between the array's `C` outputs and the downstream result sink. It frees the array to start the next accumulation while the previous results drain.

## Interface
- `DATA_WIDTH`, default 32, accumulator/element width in bits.
- `N`, default 3, array rows.
- `M`, default 3, array columns.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `load`  in  1  capture strobe from the array control; same signal that drives the MACs.
- `c_flat`  in  N·M·DATA_WIDTH  accumulators. Element k = M·i + j is `c_flat[k·DATA_WIDTH +: DATA_WIDTH]`.
- `out_data`  out  DATA_WIDTH  current element.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts the element this cycle.
- `out_index`  out  $clog2(N·M)  k of the current element.
- `out_last`  out  1  the current element is k = N·M−1.
- `busy`  out  1  a snapshot is being drained.
- `overrun`  out  1  sticky flag: a `load` was dropped.

## Operation
- States:
  - IDLE: no snapshot pending.
  - STREAM: snapshot buffer valid; `idx` selects the element.
- IDLE → STREAM on `load`:
  - Every element of `c_flat` is registered into the snapshot.
  - `idx` is set to 0.
- In STREAM, a transfer is `out_valid && out_ready`. Each transfer increments `idx`.
- Transfer with `idx` = N·M−1:
  - Go to IDLE.
  - If `load` is high in that same cycle, instead recapture, set `idx` to 0 and stay in STREAM. No overrun is flagged.
- `load` in STREAM in any other cycle:
  - The `load` is ignored and the snapshot is unchanged.
  - `overrun` is set to 1 and stays 1 until reset.
- `out_valid` = 1 exactly in STREAM.
- `out_data`, `out_index` and `out_last` reflect `idx`. They are held stable while `out_valid && !out_ready`.
- `busy` = (state == STREAM).
- `out_ready` in IDLE has no effect.
- All outputs are registered; no combinational path from `out_ready` to any output.
- `idx` never wraps past N·M−1. Unsigned compare against the constant N·M−1.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_index` = 0, `out_last` = 0, `busy` = 0, `overrun` = 0.
  - State = IDLE.
  - Snapshot cleared to 0.
- Reset asserted mid-stream: the drain is aborted immediately (asynchronously). No partial element is delivered after release.
- `load` sampled at edge t → `out_valid` = 1 with k = 0 after edge t; first transfer possible in cycle t+1.
- With `out_ready` held high: one element per cycle. A full drain takes N·M cycles; `out_last` is high on the final one.
- Back-to-back matrices: `load` coincident with the last transfer gives zero bubble cycles; k = 0 of the new snapshot follows directly.
- `c_flat` is sampled only on the capture edge; changes at other times are don't-care.

## Structure
- Shared package `systolic_pkg`:
  - Default `DATA_WIDTH`/`N`/`M` localparams shared with the array.
  - `drain_state_t` enum {IDLE, STREAM}.
  - Index-width function `$clog2(N·M)` as a `localparam`.
- Single module; no sub-module.

## Test plan
- Reset, then `load` with c = {1..9} and `out_ready` = 1 → valid from the next cycle; data 1,2,…,9 on 9 consecutive cycles; `out_last` only with 9; then IDLE, `busy` = 0.
- `out_ready` toggling 1,0,0,1,… → each element is held stable across stalls; the sequence 1..9 is complete with no duplicates; `overrun` = 0.
- `load` at k = 4 with new c = {10..18} → the stream continues with 5..9; `overrun` = 1 and stays 1.
- `load` coincident with the transfer of 9, new c = {10..18}, `out_ready` = 1 → next cycle data = 10, index 0; no idle gap; `overrun` = 0.
- `rst` asserted while k = 6 → `out_valid`, `busy`, `out_data` and `overrun` go to 0 asynchronously. After release and no `load`, `out_valid` stays 0.
- `c_flat` changed after capture, before the drain finishes → streamed values equal the captured snapshot, not the new inputs.
